avmm_wr_ack_expander_mc: RTL and testbench

AVMM_WR_ACK_EXPANDER_MC -- requirements
Module: avmm_wr_ack_expander_mc

---
 rtl/dc_bsp_pkg.sv | 14 +
 rtl/local_mem_cfg_pkg.sv | 6 +
 rtl/avmm_wr_ack_chan.sv | 134 +++++++++++++
 rtl/avmm_wr_ack_expander_mc.sv | 44 ++++
 tb/tb_avmm_wr_ack_expander_mc.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dc_bsp_pkg.sv
// Shared board-support types: write-ack reporting mode and the ack expander state encoding.
package dc_bsp_pkg;

    typedef enum logic {
        WR_ACK_PER_WORD  = 1'b0,
        WR_ACK_PER_BURST = 1'b1
    } wr_ack_mode_e;

    typedef enum logic {
        IDLE   = 1'b0,
        EXPAND = 1'b1
    } exp_state_e;

endpackage

// File: rtl/local_mem_cfg_pkg.sv
// Local memory interface configuration shared by the kernel-side AVMM adapters.
package local_mem_cfg_pkg;

    localparam int LOCAL_MEM_BURST_CNT_WIDTH = 7;

endpackage

// File: rtl/avmm_wr_ack_chan.sv
// One write channel: tracks accepted bursts and turns per-burst EMIF acks into
// per-word (or per-burst) kernel acks.
module avmm_wr_ack_chan
    import dc_bsp_pkg::*;
#(
    parameter int           BC_W       = 7,
    parameter int           FIFO_DEPTH = 64,
    parameter wr_ack_mode_e ACK_MODE   = WR_ACK_PER_WORD
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr_i,
    input  logic            waitreq_i,
    input  logic [BC_W-1:0] burstcnt_i,
    input  logic            emif_ack_i,
    output logic            ack_o,
    output logic [BC_W-1:0] ack_burstcnt_o,
    output logic            trk_full_o,
    output logic [2:0]      err_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [BC_W-1:0]  mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d, pending_q, pending_d;
    logic [BC_W-1:0]  beat_cnt_q, beat_cnt_d, remaining_q, remaining_d;
    logic [BC_W-1:0]  ack_bc_q, ack_bc_d;
    logic             ack_q, ack_d;
    logic [2:0]       err_q, err_d;
    exp_state_e       state_q, state_d;

    logic             accept, first_beat, push, push_ok, ack_in_ok, pop;
    logic [BC_W-1:0]  pop_bc;

    assign accept     = wr_i && !waitreq_i;
    assign first_beat = accept && (beat_cnt_q == '0);
    assign push       = first_beat && (burstcnt_i != '0);
    assign trk_full_o = (count_q == CNT_W'(FIFO_DEPTH));
    assign push_ok    = push && !trk_full_o;
    // An ack is legal only while some tracked burst is still waiting for one.
    assign ack_in_ok  = emif_ack_i && (pending_q != count_q);
    assign pop_bc     = mem_q[rd_ptr_q];

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        ack_d       = 1'b0;
        ack_bc_d    = '0;
        pop         = 1'b0;
        if (ACK_MODE == WR_ACK_PER_BURST) begin
            pop      = (pending_q != '0);
            ack_d    = pop;
            ack_bc_d = pop ? pop_bc : '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pending_q != '0) begin
                        pop         = 1'b1;
                        state_d     = EXPAND;
                        remaining_d = pop_bc;
                    end
                end
                EXPAND: begin
                    remaining_d = remaining_q - BC_W'(1);
                    if (remaining_q == BC_W'(1)) begin
                        if (pending_q != '0) begin
                            pop         = 1'b1;
                            remaining_d = pop_bc;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (first_beat) begin
            beat_cnt_d = (burstcnt_i == '0) ? '0 : burstcnt_i - BC_W'(1);
        end else if (accept) begin
            beat_cnt_d = beat_cnt_q - BC_W'(1);
        end
        count_d   = count_q + CNT_W'(push_ok) - CNT_W'(pop);
        pending_d = pending_q + CNT_W'(ack_in_ok) - CNT_W'(pop);
        err_d     = err_q | {first_beat && (burstcnt_i == '0),
                             emif_ack_i && !ack_in_ok,
                             push && trk_full_o};
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            pending_q   <= '0;
            beat_cnt_q  <= '0;
            remaining_q <= '0;
            ack_q       <= 1'b0;
            ack_bc_q    <= '0;
            err_q       <= '0;
            state_q     <= IDLE;
        end else begin
            wr_ptr_q    <= wr_ptr_q + PTR_W'(push_ok);
            rd_ptr_q    <= rd_ptr_q + PTR_W'(pop);
            count_q     <= count_d;
            pending_q   <= pending_d;
            beat_cnt_q  <= beat_cnt_d;
            remaining_q <= remaining_d;
            ack_q       <= ack_d;
            ack_bc_q    <= ack_bc_d;
            err_q       <= err_d;
            state_q     <= state_d;
        end
    end

    // NOTE: the storage array is not reset; pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= burstcnt_i;
        end
    end

    assign ack_o          = (ACK_MODE == WR_ACK_PER_BURST) ? ack_q : (state_q == EXPAND);
    assign ack_burstcnt_o = ack_bc_q;
    assign err_o          = err_q;

endmodule

// File: rtl/avmm_wr_ack_expander_mc.sv
// Multi-channel AVMM write-ack expander: one independent tracking channel per kernel write port.
module avmm_wr_ack_expander_mc
    import dc_bsp_pkg::*;
    import local_mem_cfg_pkg::*;
#(
    parameter int           NUM_CH              = 2,
    parameter int           AVMM_BURSTCNT_WIDTH = LOCAL_MEM_BURST_CNT_WIDTH,
    parameter int           FIFO_DEPTH          = 64,
    parameter wr_ack_mode_e ACK_MODE            = WR_ACK_PER_WORD
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_CH-1:0]                     kernel_avmm_wr,
    input  logic [NUM_CH-1:0]                     kernel_avmm_waitreq,
    input  logic [NUM_CH*AVMM_BURSTCNT_WIDTH-1:0] kernel_avmm_burstcnt,
    input  logic [NUM_CH-1:0]                     emif_avmm_wr_ack,
    output logic [NUM_CH-1:0]                     kernel_avmm_wr_ack,
    output logic [NUM_CH*AVMM_BURSTCNT_WIDTH-1:0] kernel_avmm_wr_ack_burstcnt,
    output logic [NUM_CH-1:0]                     trk_full,
    output logic [NUM_CH*3-1:0]                   err_sticky
);

    localparam int W = AVMM_BURSTCNT_WIDTH;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        avmm_wr_ack_chan #(
            .BC_W       (W),
            .FIFO_DEPTH (FIFO_DEPTH),
            .ACK_MODE   (ACK_MODE)
        ) u_chan (
            .clk            (clk),
            .reset          (reset),
            .wr_i           (kernel_avmm_wr[c]),
            .waitreq_i      (kernel_avmm_waitreq[c]),
            .burstcnt_i     (kernel_avmm_burstcnt[c*W +: W]),
            .emif_ack_i     (emif_avmm_wr_ack[c]),
            .ack_o          (kernel_avmm_wr_ack[c]),
            .ack_burstcnt_o (kernel_avmm_wr_ack_burstcnt[c*W +: W]),
            .trk_full_o     (trk_full[c]),
            .err_o          (err_sticky[c*3 +: 3])
        );
    end

endmodule

// File: tb/tb_avmm_wr_ack_expander_mc.sv
// Directed bench: per-word (deep and shallow FIFO) and pass-mode instances share one stimulus bus.
module tb_avmm_wr_ack_expander_mc;
    import dc_bsp_pkg::*;

    localparam int NC = 2;
    localparam int W  = 7;

    logic clk = 1'b0;
    logic reset;
    logic [NC-1:0]   wr, waitreq, emif_ack;
    logic [NC*W-1:0] burstcnt;

    logic [NC-1:0]   ack_w, ack_s, ack_p;
    logic [NC*W-1:0] bc_w, bc_s, bc_p;
    logic [NC-1:0]   full_w, full_s, full_p;
    logic [NC*3-1:0] err_w, err_s, err_p;

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] bc_log [32];

    always #5 clk = ~clk;

    avmm_wr_ack_expander_mc #(.NUM_CH(NC), .AVMM_BURSTCNT_WIDTH(W), .FIFO_DEPTH(64),
                              .ACK_MODE(WR_ACK_PER_WORD)) dut_word (
        .clk(clk), .reset(reset), .kernel_avmm_wr(wr), .kernel_avmm_waitreq(waitreq),
        .kernel_avmm_burstcnt(burstcnt), .emif_avmm_wr_ack(emif_ack),
        .kernel_avmm_wr_ack(ack_w), .kernel_avmm_wr_ack_burstcnt(bc_w),
        .trk_full(full_w), .err_sticky(err_w));

    avmm_wr_ack_expander_mc #(.NUM_CH(NC), .AVMM_BURSTCNT_WIDTH(W), .FIFO_DEPTH(4),
                              .ACK_MODE(WR_ACK_PER_WORD)) dut_small (
        .clk(clk), .reset(reset), .kernel_avmm_wr(wr), .kernel_avmm_waitreq(waitreq),
        .kernel_avmm_burstcnt(burstcnt), .emif_avmm_wr_ack(emif_ack),
        .kernel_avmm_wr_ack(ack_s), .kernel_avmm_wr_ack_burstcnt(bc_s),
        .trk_full(full_s), .err_sticky(err_s));

    avmm_wr_ack_expander_mc #(.NUM_CH(NC), .AVMM_BURSTCNT_WIDTH(W), .FIFO_DEPTH(64),
                              .ACK_MODE(WR_ACK_PER_BURST)) dut_pass (
        .clk(clk), .reset(reset), .kernel_avmm_wr(wr), .kernel_avmm_waitreq(waitreq),
        .kernel_avmm_burstcnt(burstcnt), .emif_avmm_wr_ack(emif_ack),
        .kernel_avmm_wr_ack(ack_p), .kernel_avmm_wr_ack_burstcnt(bc_p),
        .trk_full(full_p), .err_sticky(err_p));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        wr       = '0;
        waitreq  = '0;
        emif_ack = '0;
        burstcnt = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic drive_burst(input int ch, input int bc);
        int beats;
        beats = (bc == 0) ? 1 : bc;
        for (int i = 0; i < beats; i++) begin
            wr[ch] = 1'b1;
            burstcnt[ch*W +: W] = W'(bc);
            step();
        end
        wr[ch] = 1'b0;
    endtask

    function automatic logic sel_ack(input int which, input int ch);
        case (which)
            0:       return ack_w[ch];
            1:       return ack_s[ch];
            default: return ack_p[ch];
        endcase
    endfunction

    function automatic logic [W-1:0] sel_bc(input int which, input int ch);
        case (which)
            0:       return bc_w[ch*W +: W];
            1:       return bc_s[ch*W +: W];
            default: return bc_p[ch*W +: W];
        endcase
    endfunction

    // Pulses emif ack on ch for nacks consecutive cycles; got[i] is sampled just after edge i
    // of the first ack, so a 2-cycle latency shows up as got[1].
    task automatic capture(input int which, input int ch, input int nacks, input int n,
                           output logic [31:0] got, output logic [31:0] got_other);
        got       = '0;
        got_other = '0;
        emif_ack[ch] = 1'b1;
        step();
        for (int i = 0; i < n; i++) begin
            got[i]       = sel_ack(which, ch);
            got_other[i] = sel_ack(which, 1 - ch);
            bc_log[i]    = sel_bc(which, ch);
            emif_ack[ch] = (i + 1 < nacks);
            step();
        end
        emif_ack[ch] = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({ack_w, ack_s, ack_p} !== '0) begin
            failures++;
            $display("FAIL reset_ack: got %b expected 0", {ack_w, ack_s, ack_p});
        end
        checks++;
        if ({err_w, err_s, err_p, full_w, full_s, full_p} !== '0) begin
            failures++;
            $display("FAIL reset_err_full: got %b expected 0",
                     {err_w, err_s, err_p, full_w, full_s, full_p});
        end
        checks++;
        if ({bc_w, bc_p} !== '0) begin
            failures++;
            $display("FAIL reset_ack_burstcnt: got %h expected 0", {bc_w, bc_p});
        end
    endtask

    task automatic test_single_burst();
        logic [31:0] got, oth;
        do_reset();
        drive_burst(0, 4);
        repeat (4) step();
        checks++;
        if (ack_w !== 2'b00) begin
            failures++;
            $display("FAIL single_no_early_ack: got %b expected 00", ack_w);
        end
        capture(0, 0, 1, 8, got, oth);
        checks++;
        if (got[7:0] !== 8'b0001_1110) begin
            failures++;
            $display("FAIL single_ch0_pattern: got %b expected 00011110", got[7:0]);
        end
        checks++;
        if (oth[7:0] !== 8'b0) begin
            failures++;
            $display("FAIL single_ch1_idle: got %b expected 00000000", oth[7:0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got, oth;
        do_reset();
        drive_burst(1, 3);
        drive_burst(1, 2);
        repeat (3) step();
        capture(0, 1, 2, 10, got, oth);
        checks++;
        if (got[9:0] !== 10'b00_0011_1110) begin
            failures++;
            $display("FAIL b2b_ch1_pattern: got %b expected 0000111110", got[9:0]);
        end
        checks++;
        if (oth[9:0] !== 10'b0 || err_w !== '0) begin
            failures++;
            $display("FAIL b2b_ch0_idle_no_err: ch0 %b err %b expected 0", oth[9:0], err_w);
        end
    endtask

    task automatic test_fill();
        logic [31:0] got, oth;
        do_reset();
        for (int b = 0; b < 5; b++) begin
            drive_burst(0, 1);
            if (b == 2) begin
                checks++;
                if (full_s[0] !== 1'b0) begin
                    failures++;
                    $display("FAIL fill_not_full_at3: got %b expected 0", full_s[0]);
                end
            end else if (b == 3) begin
                checks++;
                if (full_s[0] !== 1'b1) begin
                    failures++;
                    $display("FAIL fill_full_at4: got %b expected 1", full_s[0]);
                end
            end
        end
        checks++;
        if (err_s[2:0] !== 3'b001) begin
            failures++;
            $display("FAIL fill_overflow_err: got %b expected 001", err_s[2:0]);
        end
        repeat (2) step();
        capture(1, 0, 5, 12, got, oth);
        checks++;
        if (got[11:0] !== 12'b0000_0001_1110) begin
            failures++;
            $display("FAIL fill_ack_pattern: got %b expected 000000011110", got[11:0]);
        end
        checks++;
        if (err_s[2:0] !== 3'b011 || full_s[0] !== 1'b0) begin
            failures++;
            $display("FAIL fill_orphan_err_drained: err %b full %b expected 011 0",
                     err_s[2:0], full_s[0]);
        end
    endtask

    task automatic test_zero_orphan();
        logic [31:0] got, oth;
        do_reset();
        drive_burst(0, 0);
        checks++;
        if (err_w[2:0] !== 3'b100) begin
            failures++;
            $display("FAIL zero_burst_err: got %b expected 100", err_w[2:0]);
        end
        step();
        capture(0, 0, 1, 6, got, oth);
        checks++;
        if (got[5:0] !== 6'b0 || err_w[2:0] !== 3'b110) begin
            failures++;
            $display("FAIL orphan_ack: acks %b err %b expected 000000 110", got[5:0], err_w[2:0]);
        end
        drive_burst(0, 2);
        step();
        capture(0, 0, 1, 6, got, oth);
        checks++;
        if (got[5:0] !== 6'b00_0110) begin
            failures++;
            $display("FAIL zero_then_burst2: got %b expected 000110", got[5:0]);
        end
    endtask

    task automatic test_reset_mid_expand();
        logic [31:0] got, oth;
        int n;
        do_reset();
        drive_burst(0, 8);
        step();
        emif_ack[0] = 1'b1;
        step();
        emif_ack[0] = 1'b0;
        n = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            n += int'(ack_w[0]);
        end
        checks++;
        if (n != 3) begin
            failures++;
            $display("FAIL midexp_pre_acks: got %0d expected 3", n);
        end
        reset       = 1'b1;
        emif_ack[0] = 1'b1;
        step();
        checks++;
        if ({ack_w, bc_w, full_w, err_w} !== '0) begin
            failures++;
            $display("FAIL midexp_outputs_in_reset: got %h expected 0", {ack_w, bc_w, full_w, err_w});
        end
        step();
        reset       = 1'b0;
        emif_ack[0] = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            n += int'(ack_w[0]);
        end
        checks++;
        if (n != 0 || err_w !== '0) begin
            failures++;
            $display("FAIL midexp_post_reset_quiet: acks %0d err %b expected 0 0", n, err_w);
        end
        drive_burst(0, 2);
        step();
        capture(0, 0, 1, 8, got, oth);
        checks++;
        if (got[7:0] !== 8'b0000_0110) begin
            failures++;
            $display("FAIL midexp_new_burst2: got %b expected 00000110", got[7:0]);
        end
    endtask

    task automatic test_pass_mode();
        logic [31:0] got, oth;
        do_reset();
        drive_burst(0, 7);
        drive_burst(0, 1);
        step();
        capture(2, 0, 2, 8, got, oth);
        checks++;
        if (got[7:0] !== 8'b0000_0110) begin
            failures++;
            $display("FAIL pass_ack_pattern: got %b expected 00000110", got[7:0]);
        end
        checks++;
        if (bc_log[1] !== 7'd7 || bc_log[2] !== 7'd1) begin
            failures++;
            $display("FAIL pass_ack_burstcnt: got %0d,%0d expected 7,1", bc_log[1], bc_log[2]);
        end
        checks++;
        if (bc_log[3] !== 7'd0 || bc_w !== '0) begin
            failures++;
            $display("FAIL pass_bc_idle: pass %0d word %h expected 0 0", bc_log[3], bc_w);
        end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_back_to_back();
        test_fill();
        test_zero_orphan();
        test_reset_mid_expand();
        test_pass_mode();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
